// File: rtl/bcd_to_binary.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary
// Description : Converts a packed unsigned BCD number to binary using reverse
//               double-dabble (shift right, then subtract 3 from every nibble
//               >= 8). One result bit is resolved every two clock cycles.
//
// Ports       :
//   i_Clock     in   1                   clock, rising edge
//   i_Rst_L     in   1                   synchronous active-low reset
//   i_BCD       in   4*DECIMAL_DIGITS    packed BCD, digit 0 in [3:0]
//   i_Start     in   1                   request, accepted only when idle
//   o_Binary    out  OUTPUT_WIDTH        result, held until next o_DV
//   o_DV        out  1                   one-cycle result-valid pulse
//   o_Busy      out  1                   accept edge through o_DV cycle
//   o_Overflow  out  1                   value exceeds 2^OUTPUT_WIDTH-1
//   o_Error     out  1                   some input nibble > 9
//
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 3,
    parameter int OUTPUT_WIDTH   = 10
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_L,
    input  logic [4*DECIMAL_DIGITS-1:0] i_BCD,
    input  logic                        i_Start,
    output logic [OUTPUT_WIDTH-1:0]     o_Binary,
    output logic                        o_DV,
    output logic                        o_Busy,
    output logic                        o_Overflow,
    output logic                        o_Error
);

    localparam int c_BCD_WIDTH = 4 * DECIMAL_DIGITS;
    localparam int c_CNT_WIDTH = $clog2(OUTPUT_WIDTH) + 1;

    localparam logic [c_CNT_WIDTH-1:0] c_CNT_LAST = c_CNT_WIDTH'(OUTPUT_WIDTH - 1);
    localparam logic [c_CNT_WIDTH-1:0] c_CNT_ONE  = c_CNT_WIDTH'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT  = 2'd1;
    localparam logic [1:0] c_ST_ADJUST = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [c_BCD_WIDTH-1:0]    r_bcd;
    logic [OUTPUT_WIDTH-1:0]   r_bin;
    logic [c_CNT_WIDTH-1:0]    r_count;
    logic                      r_invalid;

    logic [OUTPUT_WIDTH-1:0]   r_binary;
    logic                      r_dv;
    logic                      r_busy;
    logic                      r_overflow;
    logic                      r_error;

    logic [DECIMAL_DIGITS-1:0] w_nib_invalid;
    logic                      w_invalid;
    logic [c_BCD_WIDTH-1:0]    w_bcd_adj;

    // Per-nibble logic: invalid-digit detect on the incoming word, and the
    // post-shift correction on the working register. A nibble >= 8 after a
    // right shift picked up the upper digit's LSB as 8 instead of 5, hence -3.
    // Each nibble wraps independently; no borrow crosses digit boundaries.
    genvar gi;
    generate
        for (gi = 0; gi < DECIMAL_DIGITS; gi++) begin : g_nibble
            assign w_nib_invalid[gi] = (i_BCD[4*gi +: 4] > 4'd9);
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd8)
                                        ? (r_bcd[4*gi +: 4] - 4'd3)
                                        : r_bcd[4*gi +: 4];
        end
    endgenerate

    assign w_invalid = |w_nib_invalid;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (i_Start) w_next_state = c_ST_SHIFT;
            c_ST_SHIFT:  w_next_state = c_ST_ADJUST;
            c_ST_ADJUST: w_next_state = (r_count == c_CNT_LAST) ? c_ST_DONE : c_ST_SHIFT;
            c_ST_DONE:   w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_state    <= c_ST_IDLE;
            r_bcd      <= '0;
            r_bin      <= '0;
            r_count    <= '0;
            r_invalid  <= 1'b0;
            r_binary   <= '0;
            r_dv       <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_dv    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // Busy stays high through the o_DV cycle (spent in IDLE)
                    // and drops on the following edge unless a new request
                    // is accepted on that same edge.
                    r_busy <= i_Start;
                    if (i_Start) begin
                        r_bcd     <= i_BCD;
                        r_bin     <= '0;
                        r_count   <= '0;
                        r_invalid <= w_invalid;
                    end
                end
                c_ST_SHIFT: begin
                    {r_bcd, r_bin} <= {r_bcd, r_bin} >> 1;
                end
                c_ST_ADJUST: begin
                    r_bcd   <= w_bcd_adj;
                    r_count <= r_count + c_CNT_ONE;
                end
                c_ST_DONE: begin
                    // Whatever decimal value is left in r_bcd after all
                    // shifts is the part that did not fit in OUTPUT_WIDTH.
                    r_dv    <= 1'b1;
                    r_error <= r_invalid;
                    if (r_invalid) begin
                        r_binary   <= '0;
                        r_overflow <= 1'b0;
                    end else begin
                        r_binary   <= r_bin;
                        r_overflow <= (r_bcd != '0);
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_Binary   = r_binary;
    assign o_DV       = r_dv;
    assign o_Busy     = r_busy;
    assign o_Overflow = r_overflow;
    assign o_Error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_binary
// Description : Self-checking bench for bcd_to_binary. Two instances share
//               one stimulus stream: OUTPUT_WIDTH=10 (no overflow possible)
//               and OUTPUT_WIDTH=8 (overflow above 255). A decimal reference
//               model predicts every result and its o_DV cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_binary;

    localparam int c_WA = 10;
    localparam int c_WB = 8;

    logic              clk;
    logic              rst_n;
    logic [11:0]       bcd;
    logic              start;

    logic [c_WA-1:0]   a_bin;
    logic              a_dv, a_busy, a_ovf, a_err;
    logic [c_WB-1:0]   b_bin;
    logic              b_dv, b_busy, b_ovf, b_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [15:0] bin;
        logic        ovf;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ha;
    exp_t hb;

    bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(c_WA)) u_dut_a (
        .i_Clock   (clk),
        .i_Rst_L   (rst_n),
        .i_BCD     (bcd),
        .i_Start   (start),
        .o_Binary  (a_bin),
        .o_DV      (a_dv),
        .o_Busy    (a_busy),
        .o_Overflow(a_ovf),
        .o_Error   (a_err)
    );

    bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(c_WB)) u_dut_b (
        .i_Clock   (clk),
        .i_Rst_L   (rst_n),
        .i_BCD     (bcd),
        .i_Start   (start),
        .o_Binary  (b_bin),
        .o_DV      (b_dv),
        .o_Busy    (b_busy),
        .o_Overflow(b_ovf),
        .o_Error   (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", nm, act, exp_v, cyc);
        end
    endtask

    // Decimal reference: sum digits as plain integers, then fold to width.
    function automatic exp_t model(input logic [11:0] v, input int w, input int due);
        exp_t e;
        int   val;
        logic bad;
        val = 0;
        bad = 1'b0;
        for (int d = 2; d >= 0; d--) begin
            if (v[4*d +: 4] > 4'd9) bad = 1'b1;
            val = val * 10 + int'(v[4*d +: 4]);
        end
        e.due = due;
        e.err = bad;
        if (bad) begin
            e.bin = '0;
            e.ovf = 1'b0;
        end else begin
            e.bin = 16'(val % (1 << w));
            e.ovf = (val > (1 << w) - 1);
        end
        return e;
    endfunction

    // Model of acceptance plus per-cycle comparison of both instances.
    initial begin
        ha = '{0, 16'd0, 1'b0, 1'b0};
        hb = '{0, 16'd0, 1'b0, 1'b0};
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                qa.delete();
                qb.delete();
                ha = '{0, 16'd0, 1'b0, 1'b0};
                hb = '{0, 16'd0, 1'b0, 1'b0};
            end else if (start) begin
                if (qa.size() == 0) qa.push_back(model(bcd, c_WA, cyc + 2*c_WA + 1));
                if (qb.size() == 0) qb.push_back(model(bcd, c_WB, cyc + 2*c_WB + 1));
            end
            #1;
            chk("a_busy", 16'(a_busy), 16'(qa.size() != 0));
            if (qa.size() != 0 && cyc == qa[0].due) begin
                chk("a_dv", 16'(a_dv), 16'd1);
                ha = qa.pop_front();
            end else begin
                chk("a_dv", 16'(a_dv), 16'd0);
            end
            chk("a_bin", 16'(a_bin), ha.bin);
            chk("a_ovf", 16'(a_ovf), 16'(ha.ovf));
            chk("a_err", 16'(a_err), 16'(ha.err));

            chk("b_busy", 16'(b_busy), 16'(qb.size() != 0));
            if (qb.size() != 0 && cyc == qb[0].due) begin
                chk("b_dv", 16'(b_dv), 16'd1);
                hb = qb.pop_front();
            end else begin
                chk("b_dv", 16'(b_dv), 16'd0);
            end
            chk("b_bin", 16'(b_bin), hb.bin);
            chk("b_ovf", 16'(b_ovf), 16'(hb.ovf));
            chk("b_err", 16'(b_err), 16'(hb.err));
        end
    end

    task automatic pulse(input logic [11:0] v);
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcd   = 12'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 16'(qa.size() + qb.size()), 16'd0);
    endtask

    task automatic convert(input logic [11:0] v);
        pulse(v);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] v;
        int          n;

        rst_n = 1'b0;
        start = 1'b0;
        bcd   = 12'h000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_bin", 16'(a_bin), 16'd0);
        chk("rst_dv", 16'(a_dv), 16'd0);
        chk("rst_busy", 16'(a_busy), 16'd0);

        // Basic conversion, literal pins
        convert(12'h012);
        chk("lit_012_bin", 16'(a_bin), 16'd12);
        chk("lit_012_ovf", 16'(a_ovf), 16'd0);
        chk("lit_012_err", 16'(a_err), 16'd0);

        convert(12'h000);
        chk("lit_000", 16'(a_bin), 16'd0);
        convert(12'h999);
        chk("lit_999", 16'(a_bin), 16'd999);
        convert(12'h255);
        chk("lit_255", 16'(a_bin), 16'd255);
        chk("lit_255_b", 16'(b_bin), 16'd255);
        chk("lit_255_b_ovf", 16'(b_ovf), 16'd0);
        convert(12'h100);
        chk("lit_100", 16'(a_bin), 16'd100);
        convert(12'h256);
        chk("lit_256_b", 16'(b_bin), 16'd0);
        chk("lit_256_b_ovf", 16'(b_ovf), 16'd1);
        chk("lit_256_a", 16'(a_bin), 16'd256);
        convert(12'h0A5);
        chk("lit_0a5_err", 16'(a_err), 16'd1);
        chk("lit_0a5_bin", 16'(a_bin), 16'd0);

        // Start while busy is ignored
        pulse(12'h345);
        repeat (3) @(negedge clk);
        pulse(12'h678);
        wait_idle();
        chk("lit_busy_345", 16'(a_bin), 16'd345);

        // Start held high; input changes after acceptance must not matter
        @(negedge clk);
        bcd   = 12'h123;
        start = 1'b1;
        @(negedge clk);
        bcd   = 12'h456;
        repeat (29) @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("lit_held_456", 16'(a_bin), 16'd456);

        // Reset in the middle of a conversion
        pulse(12'h777);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_bin", 16'(a_bin), 16'd0);
        chk("midrst_busy", 16'(a_busy), 16'd0);
        repeat (30) @(negedge clk);
        convert(12'h321);
        chk("lit_after_rst", 16'(a_bin), 16'd321);

        // Loopback: every decimal value 0..999 round-trips
        for (int k = 0; k < 1000; k++) begin
            v = {4'(k / 100), 4'((k / 10) % 10), 4'(k % 10)};
            convert(v);
        end

        // Random values (some with invalid digits) and random start timing
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                v = 12'($urandom);
            end else begin
                n = $urandom_range(0, 999);
                v = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
            end
            pulse(v);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                pulse(12'($urandom));
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_to_binary.md
# bcd_to_binary

- Converts a packed unsigned BCD number into a plain binary value using the reverse double-dabble algorithm (shift right, then subtract 3).
- One bit is resolved per two clock cycles.
- It is the inverse of the existing binary-to-BCD converter. It sits on the input path where decimal data (keypad or UART-entered digits) must become a binary count.
- Handshake is start/data-valid, the same style as the forward converter, so the two can be chained back-to-back for loopback checks.

## Interface

- DECIMAL_DIGITS, 3, number of BCD digits on i_BCD (input width is 4*DECIMAL_DIGITS).
- OUTPUT_WIDTH, 10, width of o_Binary and number of shift iterations. Must be ≥1.
- i_Clock  in  1  clock; all logic on the rising edge.
- i_Rst_L  in  1  reset; synchronous, active-low.
- i_BCD  in  4*DECIMAL_DIGITS  packed BCD. Digit 0 (ones) is in bits [3:0]. Sampled only on the edge that accepts i_Start.
- i_Start  in  1  request pulse. Accepted only when idle; ignored while busy.
- o_Binary  out  OUTPUT_WIDTH  result. Held stable from the o_DV cycle until the next o_DV.
- o_DV  out  1  single-cycle pulse: o_Binary, o_Overflow and o_Error are valid.
- o_Busy  out  1  high from the accepting edge until the o_DV cycle, inclusive.
- o_Overflow  out  1  input value exceeds 2^OUTPUT_WIDTH-1. Valid with o_DV; held like o_Binary.
- o_Error  out  1  at least one input nibble > 9. Valid with o_DV; held like o_Binary.

## Operation

- **Working register:** {bcd (4*DECIMAL_DIGITS bits), bin (OUTPUT_WIDTH bits)}. Loop counter width is clog2(OUTPUT_WIDTH)+1.
- **State machine:** IDLE, SHIFT, ADJUST, DONE.
- **IDLE**
  - If i_Start=1: load bcd<=i_Bcd, bin<=0, count<=0.
  - Latch invalid-digit flag = OR over all nibbles of (nibble > 9).
  - Go to SHIFT.
- **SHIFT**
  - {bcd,bin} <= {bcd,bin} >> 1. A 0 enters the bcd MSB; the bcd LSB enters the bin MSB.
  - Go to ADJUST.
- **ADJUST**
  - Every bcd nibble ≥ 8 has 3 subtracted, all nibbles in parallel in one cycle. Nibble arithmetic is 4-bit, with no borrow between nibbles.
  - count <= count+1. If count == OUTPUT_WIDTH-1, go to DONE; else go to SHIFT.
- **DONE**
  - o_Binary <= bin, o_Overflow <= (bcd != 0), o_Error <= invalid flag.
  - If the invalid flag is set, o_Binary <= 0 and o_Overflow <= 0.
  - o_DV <= 1 for one cycle; return to IDLE.
- **Start handling:** i_Start is level-sampled only in IDLE. i_Start held high continuously produces back-to-back conversions with one IDLE cycle between them.
- **Overflow:** is possible only when 10^DECIMAL_DIGITS-1 > 2^OUTPUT_WIDTH-1. When it occurs, o_Binary holds the low OUTPUT_WIDTH bits of the true value.

## Timing

- **Reset (i_Rst_L=0 at an edge):**
  - State goes to IDLE.
  - o_Binary=0, o_DV=0, o_Busy=0, o_Overflow=0, o_Error=0.
  - Working register and counter are cleared.
  - Takes priority over i_Start.
  - Mid-conversion reset aborts the conversion with no o_DV pulse.
- **Latency:** i_Start is accepted at edge 0. o_DV is high in the cycle after edge 2*OUTPUT_WIDTH+1, i.e. edge 21 for the defaults.
- **o_Busy:** rises after edge 0 and falls together with o_DV.
- **Back-to-back:** a new i_Start can be accepted no earlier than the edge that ends the o_DV cycle. Conversion period is 2*OUTPUT_WIDTH+2 cycles.
- **Input hold:** i_BCD changes after the accepting edge do not affect the result.

## Test plan

- **Reset values:** reset asserted for 3 cycles, then released → all outputs 0 and o_Busy=0; no o_DV without i_Start.
- **Basic conversion:** i_BCD=12'h012 with a one-cycle i_Start → o_Binary=10'd12 and o_DV high exactly 21 edges after acceptance; o_Overflow=0, o_Error=0.
- **Boundary values:** 12'h000 → 0; 12'h999 → 999; 12'h255 → 255; 12'h100 → 100. Each completes with one o_DV pulse.
- **Overflow, invalid input and loopback:**
  - Second instance, DECIMAL_DIGITS=3, OUTPUT_WIDTH=8: 12'h255 → 255 with o_Overflow=0; 12'h256 → o_Overflow=1, o_Binary=8'd0.
  - 12'h0A5 → o_Error=1, o_Binary=0.
  - Loopback through binary-to-BCD: all 0..999 round-trip exactly.
- **Start while busy:** i_Start pulsed with 12'h345, then pulsed again with 12'h678 at cycle 5 → that second start is ignored; one o_DV with o_Binary=345.
- **Start held and reset mid-operation:**
  - i_Start held high → consecutive o_DV pulses 22 cycles apart.
  - Reset asserted at cycle 8 of a conversion → no o_DV; outputs 0.
  - The next start converts correctly.
